// File: rtl/shifter_seq_unit.sv
// Iterative shifter/rotator: one bit position per clock with a START/BUSY/DONE handshake.
// Supports ROR, ROL, LSR, LSL and ASR; MODE 101-111 passes A through unchanged.
module shifter_seq_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] AMT,
  input  logic [2:0]       MODE,
  output logic [WIDTH-1:0] C,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  localparam logic [AMT_W-1:0] AmtZero = '0;
  localparam logic [AMT_W-1:0] AmtOne  = AmtZero + 1'b1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] step_val;
  logic             step_co;
  logic             pass;

  // Modes 101..111 behave as a zero-length shift whatever AMT says.
  assign pass = MODE[2] & (MODE[1:0] != 2'b00);

  always_comb begin
    step_val = work_q;
    step_co  = 1'b0;
    case (mode_q)
      3'b000: begin
        step_val = {work_q[0], work_q[WIDTH-1:1]};
        step_co  = work_q[0];
      end
      3'b001: begin
        step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        step_co  = work_q[WIDTH-1];
      end
      3'b010: begin
        step_val = {1'b0, work_q[WIDTH-1:1]};
        step_co  = work_q[0];
      end
      3'b011: begin
        step_val = {work_q[WIDTH-2:0], 1'b0};
        step_co  = work_q[WIDTH-1];
      end
      3'b100: begin
        step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_co  = work_q[0];
      end
      default: begin
        step_val = work_q;
        step_co  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    c_d     = c_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          work_d = A;
          mode_d = MODE;
          cnt_d  = AMT;
          if (pass || (AMT == AmtZero)) begin
            state_d = StFinish;
            cnt_d   = AmtZero;
            c_d     = A;
            carry_d = 1'b0;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = step_val;
        cnt_d  = cnt_q - AmtOne;
        // The final step's result goes straight to the output registers.
        if (cnt_q == AmtOne) begin
          state_d = StFinish;
          c_d     = step_val;
          carry_d = step_co;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      carry_q <= carry_d;
    end
  end

  assign C     = c_q;
  assign CARRY = carry_q;
  assign BUSY  = (state_q == StShift);
  assign DONE  = (state_q == StFinish);

endmodule

// File: tb/tb_shifter_seq_unit.sv
// Bench for shifter_seq_unit: per-cycle comparison against a cycle-level reference model,
// directed cases with literal results, then randomized traffic.
module tb_shifter_seq_unit;

  localparam int W = 8;

  logic         CLK, RST, START;
  logic [W-1:0] A;
  logic [2:0]   AMT;
  logic [2:0]   MODE;
  logic [W-1:0] C;
  logic         CARRY, BUSY, DONE;

  int total = 0;
  int bad   = 0;

  shifter_seq_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .AMT(AMT), .MODE(MODE),
    .C(C), .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation result from plain arithmetic on the operand.
  function automatic void ref_op(input logic [W-1:0] a, input int amt, input logic [2:0] mode,
                                 output logic [W-1:0] c, output logic cy);
    c  = a;
    cy = 1'b0;
    if (mode <= 3'd4 && amt != 0) begin
      case (mode)
        3'd0: begin c = (a >> amt) | (a << (W - amt)); cy = a[amt-1]; end
        3'd1: begin c = (a << amt) | (a >> (W - amt)); cy = a[W-amt]; end
        3'd2: begin c = a >> amt; cy = a[amt-1]; end
        3'd3: begin c = a << amt; cy = a[W-amt]; end
        default: begin
          c  = (a >> amt) | (a[W-1] ? ~(8'hFF >> amt) : 8'h00);
          cy = a[amt-1];
        end
      endcase
    end
  endfunction

  // Reference timeline: AMT busy cycles after acceptance, then one DONE cycle.
  int           m_cnt  = 0;
  bit           m_done = 0;
  logic [W-1:0] m_c    = '0;
  logic         m_cy   = 1'b0;

  initial begin
    logic [W-1:0] pc;
    logic         pcy;
    int           eff;
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_cnt = 0; m_done = 0; m_c = '0; m_cy = 1'b0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_done = 1; m_c = pc; m_cy = pcy; end
      end else if (START) begin
        ref_op(A, int'(AMT), MODE, pc, pcy);
        eff = (MODE <= 3'd4) ? int'(AMT) : 0;
        if (eff == 0) begin m_done = 1; m_c = pc; m_cy = pcy; end
        else m_cnt = eff;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      check("c", C, m_c);
      check("carry", {7'd0, CARRY}, {7'd0, m_cy});
      check("busy", {7'd0, BUSY}, {7'd0, (m_cnt > 0)});
      check("done", {7'd0, DONE}, {7'd0, m_done});
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] a, input int amt,
                        input logic [2:0] mode, input logic [W-1:0] ec, input logic ecy,
                        input int elat);
    int lat;
    @(posedge CLK); #2;
    A = a; AMT = 3'(amt); MODE = mode; START = 1'b1;
    @(posedge CLK); #2;
    START = 1'b0; A = ~a; AMT = 3'(amt + 3); MODE = mode ^ 3'b011;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (DONE) begin lat = i; break; end
    end
    check({name, "_lat"}, 8'(lat), 8'(elat));
    check({name, "_c"}, C, ec);
    check({name, "_carry"}, {7'd0, CARRY}, {7'd0, ecy});
  endtask

  initial begin
    int ndone;
    logic [W-1:0] first_c;
    RST = 1'b1; START = 1'b0; A = '0; AMT = '0; MODE = '0;
    repeat (3) @(posedge CLK);
    #3;
    check("rst_c", C, 8'h00);
    check("rst_busy", {7'd0, BUSY}, 8'h00);
    RST = 1'b0;

    run_op("ror3", 8'h96, 3, 3'b000, 8'hD2, 1'b1, 4);
    run_op("lsl2", 8'h96, 2, 3'b011, 8'h58, 1'b0, 3);
    run_op("lsr1", 8'h01, 1, 3'b010, 8'h00, 1'b1, 2);
    run_op("asr7", 8'h96, 7, 3'b100, 8'hFF, 1'b0, 8);
    run_op("rol1", 8'h81, 1, 3'b001, 8'h03, 1'b1, 2);
    run_op("rol0", 8'h3C, 0, 3'b001, 8'h3C, 1'b0, 1);
    run_op("pass", 8'h5A, 5, 3'b101, 8'h5A, 1'b0, 1);

    // Second START while shifting must be dropped.
    @(posedge CLK); #2;
    A = 8'h96; AMT = 3'd5; MODE = 3'b000; START = 1'b1;
    @(posedge CLK); #2; START = 1'b0;
    @(posedge CLK); #2; A = 8'h00; START = 1'b1;
    @(posedge CLK); #2; START = 1'b0;
    ndone = 0; first_c = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE) begin
        if (ndone == 0) first_c = C;
        ndone++;
      end
    end
    check("ign_ndone", 8'(ndone), 8'd1);
    check("ign_c", first_c, 8'hB4);

    // Asynchronous reset in the middle of a shift.
    @(posedge CLK); #2;
    A = 8'hFF; AMT = 3'd6; MODE = 3'b011; START = 1'b1;
    @(posedge CLK); #2; START = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("arst_c", C, 8'h00);
    check("arst_carry", {7'd0, CARRY}, 8'h00);
    check("arst_busy", {7'd0, BUSY}, 8'h00);
    check("arst_done", {7'd0, DONE}, 8'h00);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    run_op("post_rst", 8'h01, 4, 3'b011, 8'h10, 1'b0, 5);

    repeat (500) begin
      @(posedge CLK); #2;
      START = ($urandom_range(0, 2) == 0);
      A     = 8'($urandom);
      AMT   = 3'($urandom_range(0, 7));
      MODE  = 3'($urandom_range(0, 7));
    end
    START = 1'b0;
    repeat (12) @(posedge CLK);
    @(negedge CLK); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter_seq_unit.md
Name: shifter_seq_unit

Overview:
- Iterative, parametrised shifter/rotator. Shifts a WIDTH-bit operand by a run-time amount, one bit position per clock.
- Supports rotate, logical and arithmetic modes. Reports the last bit shifted out.
- Uses a START/BUSY/DONE handshake so the ALU core can issue multi-position shifts without a wide barrel network.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- AMT_W, $clog2(WIDTH), width of the shift-amount port

Ports:
- CLK  input  1  single system clock, rising-edge
- RST  input  1  reset, asynchronous, active-high
- START  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand, captured on an accepted START
- AMT  input  AMT_W  shift count 0..WIDTH-1, captured on an accepted START
- MODE  input  3  operation, captured on an accepted START
- C  output  WIDTH  result; holds its value until the next DONE
- CARRY  output  1  last bit shifted/rotated out
- BUSY  output  1  high while shifting
- DONE  output  1  one-cycle pulse; C/CARRY valid

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is asynchronous and active-high.
- Reset: state=IDLE; C=0, CARRY=0, BUSY=0, DONE=0; working register and counter cleared.
- Reset mid-operation: aborts immediately. No DONE pulse; outputs return to reset values.
- MODE encoding:
  - 000 ROR: rotate right, CARRY=bit wrapped out of bit 0
  - 001 ROL: rotate left, CARRY=bit wrapped out of bit WIDTH-1
  - 010 LSR: logical right, zero fill, CARRY=bit 0 out
  - 011 LSL: logical left, zero fill, CARRY=bit WIDTH-1 out
  - 100 ASR: arithmetic right, sign (MSB) replicated, CARRY=bit 0 out
  - 101–111: pass-through. Treated as AMT=0 regardless of AMT: C=A, CARRY=0.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE: START=1 latches A/AMT/MODE at the edge. If effective AMT=0, go to FINISH; else go to SHIFT with count=AMT.
  - SHIFT: BUSY=1. Each edge performs one single-position step per MODE, updates the internal carry, and decrements count. When count reaches 0, go to FINISH.
  - FINISH: DONE=1, BUSY=0. C and CARRY are registered on entry to FINISH. Next edge returns to IDLE.
- Timing: START high in cycle t. BUSY is high in cycles t+1..t+AMT. DONE is high in cycle t+AMT+1. Total latency is AMT+1 cycles. With AMT=0, DONE is in t+1 and BUSY never rises.
- START in SHIFT or FINISH is ignored; no queuing. A new START is accepted the cycle after DONE (in IDLE). Back-to-back throughput is one operation per AMT+2 cycles.
- A/AMT/MODE changes after acceptance have no effect on the in-flight operation.
- C and CARRY change only on entry to FINISH or on reset. BUSY and DONE are never high together.
- CARRY with AMT=0 is 0.
- No AMT ≥ WIDTH case exists, because the port width bounds the amount.

Test Plan:
- ROR, A=0x96, AMT=3, START at t → BUSY t+1..t+3; DONE at t+4; C=0xD2, CARRY=1.
- LSL, A=0x96, AMT=2 → C=0x58, CARRY=0, DONE at t+3. Then LSR, A=0x01, AMT=1 → C=0x00, CARRY=1.
- ASR, A=0x96, AMT=7 → BUSY for 7 cycles; C=0xFF, CARRY=0, DONE at t+8. Then ROL, A=0x81, AMT=1 → C=0x03, CARRY=1.
- ROL, A=0x3C, AMT=0 → BUSY stays 0; DONE at t+1; C=0x3C, CARRY=0. MODE=101, A=0x5A, AMT=5 → C=0x5A, DONE at t+1.
- ROR, A=0x96, AMT=5; pulse START with A=0x00 at t+2 → second START ignored; C=0xB4 at t+6; exactly one DONE pulse.
- LSL, A=0xFF, AMT=6; assert RST asynchronously mid-cycle at t+3 → C, CARRY, BUSY, DONE drop to 0 immediately with no DONE. After release, LSL, A=0x01, AMT=4 → C=0x10, CARRY=0.
